// File: rtl/cpu_bus_ctrl.sv
// Bus-timing controller for the 6502 core: clk_en divider, stretched CPU reset and slow-region wait states.
// Define CPU_BUS_CTRL_WAIT_EN to build in the wait-state FSM; without it every slot issues clk_en.
module cpu_bus_ctrl #(
    parameter int unsigned CLK_DIV        = 10,
    parameter int unsigned RST_ASSERT_LEN = 10,
    parameter int unsigned WAIT_STATES    = 2,
    parameter logic [15:0] SLOW_BASE      = 16'h8000,
    parameter logic [15:0] SLOW_LIMIT     = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr,
    output logic        clk_en,
    output logic        cpu_rstn,
    output logic        busy,
    output logic [15:0] stall_cnt
);

    logic [7:0] div_q;
    logic [7:0] div_d;
    logic       slot;
    logic       suppress;
    logic       clk_en_q;
    logic       cpu_rstn_q;
    logic       cpu_rstn_d;
    logic [7:0] rst_cnt_q;
    logic [7:0] rst_cnt_d;

    assign slot  = (div_q == 8'(CLK_DIV - 1));
    assign div_d = slot ? '0 : div_q + 8'd1;

    // A pulse is counted on the edge that ends it, so release coincides with clk_en falling.
    always_comb begin
        rst_cnt_d  = rst_cnt_q;
        cpu_rstn_d = cpu_rstn_q;
        if (clk_en_q && !cpu_rstn_q) begin
            rst_cnt_d  = rst_cnt_q + 8'd1;
            cpu_rstn_d = (rst_cnt_d == 8'(RST_ASSERT_LEN));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q      <= '0;
            clk_en_q   <= 1'b0;
            cpu_rstn_q <= 1'b0;
            rst_cnt_q  <= '0;
        end else begin
            div_q      <= div_d;
            clk_en_q   <= slot && !suppress;
            cpu_rstn_q <= cpu_rstn_d;
            rst_cnt_q  <= rst_cnt_d;
        end
    end

    assign clk_en   = clk_en_q;
    assign cpu_rstn = cpu_rstn_q;

`ifdef CPU_BUS_CTRL_WAIT_EN
    typedef enum logic {ST_RUN, ST_WAIT} state_e;

    state_e      state_q;
    state_e      state_d;
    logic [3:0]  wcnt_q;
    logic [3:0]  wcnt_d;
    logic        busy_q;
    logic [15:0] stall_q;
    logic [15:0] stall_d;
    logic        slow_hit;

    assign slow_hit = (WAIT_STATES != 0) && (addr >= SLOW_BASE) && (addr <= SLOW_LIMIT);

    always_comb begin
        state_d  = state_q;
        wcnt_d   = wcnt_q;
        suppress = 1'b0;
        if (slot) begin
            case (state_q)
                ST_RUN: begin
                    if (cpu_rstn_q && slow_hit) begin
                        suppress = 1'b1;
                        wcnt_d   = 4'(WAIT_STATES - 1);
                        state_d  = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (wcnt_q != 4'd0) begin
                        suppress = 1'b1;
                        wcnt_d   = wcnt_q - 4'd1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                default: state_d = ST_RUN;
            endcase
        end
        stall_d = (suppress && (stall_q != '1)) ? stall_q + 16'd1 : stall_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            wcnt_q  <= '0;
            busy_q  <= 1'b0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            busy_q  <= (state_d == ST_WAIT);
            stall_q <= stall_d;
        end
    end

    assign busy      = busy_q;
    assign stall_cnt = stall_q;
`else
    logic unused_wait_cfg;

    assign suppress        = 1'b0;
    assign busy            = 1'b0;
    assign stall_cnt       = '0;
    assign unused_wait_cfg = ^{addr, SLOW_BASE, SLOW_LIMIT, 32'(WAIT_STATES)};
`endif

endmodule

// File: tb/tb_cpu_bus_ctrl.sv
// Directed bench for cpu_bus_ctrl (CLK_DIV=4, RST_ASSERT_LEN=3, WAIT_STATES=2, plus a WAIT_STATES=0 instance).
// Expectations follow CPU_BUS_CTRL_WAIT_EN the same way the design does.
module tb_cpu_bus_ctrl;

    logic        clk  = 1'b0;
    logic        rst  = 1'b1;
    logic [15:0] addr = 16'h0200;
    logic        clk_en;
    logic        cpu_rstn;
    logic        busy;
    logic [15:0] stall_cnt;

    logic [15:0] addr0 = 16'h8000;
    logic        clk_en0;
    logic        cpu_rstn0;
    logic        busy0;
    logic [15:0] stall_cnt0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cpu_bus_ctrl #(
        .CLK_DIV(4), .RST_ASSERT_LEN(3), .WAIT_STATES(2),
        .SLOW_BASE(16'h8000), .SLOW_LIMIT(16'hFFFF)
    ) dut (
        .clk(clk), .rst(rst), .addr(addr), .clk_en(clk_en),
        .cpu_rstn(cpu_rstn), .busy(busy), .stall_cnt(stall_cnt)
    );

    cpu_bus_ctrl #(
        .CLK_DIV(4), .RST_ASSERT_LEN(3), .WAIT_STATES(0),
        .SLOW_BASE(16'h8000), .SLOW_LIMIT(16'hFFFF)
    ) dut0 (
        .clk(clk), .rst(rst), .addr(addr0), .clk_en(clk_en0),
        .cpu_rstn(cpu_rstn0), .busy(busy0), .stall_cnt(stall_cnt0)
    );

    // Advances to the next negedge at which clk_en is high; returns with the divider at 0.
    task automatic wait_pulse(input bit use0, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if ((use0 ? clk_en0 : clk_en) === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        logic exp_en;
        logic exp_rn;
        addr = 16'h8000;
        rst  = 1'b1;
        repeat (5) @(negedge clk);
        checks++; if (clk_en !== 1'b0) begin errors++; $display("FAIL reset_clk_en: got %b want 0", clk_en); end
        checks++; if (cpu_rstn !== 1'b0) begin errors++; $display("FAIL reset_cpu_rstn: got %b want 0", cpu_rstn); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (stall_cnt !== 16'h0000) begin errors++; $display("FAIL reset_stall_cnt: got %h want 0000", stall_cnt); end
        rst = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            exp_en = (k % 4 == 0);
            exp_rn = (k >= 13);
            checks++; if (clk_en !== exp_en) begin errors++; $display("FAIL stretch_clk_en k=%0d: got %b want %b", k, clk_en, exp_en); end
            checks++; if (cpu_rstn !== exp_rn) begin errors++; $display("FAIL stretch_cpu_rstn k=%0d: got %b want %b", k, cpu_rstn, exp_rn); end
            if (k == 12) addr = 16'h0200;
        end
        checks++; if (stall_cnt !== 16'h0000) begin errors++; $display("FAIL stretch_stall_cnt: got %h want 0000", stall_cnt); end
    endtask

    task automatic test_fast();
        bit   ok;
        logic exp_en;
        addr = 16'h0200;
        wait_pulse(1'b0, ok);
        checks++; if (!ok) begin errors++; $display("FAIL fast_sync: got no clk_en within 40 cycles, want a pulse"); end
        for (int j = 1; j <= 12; j++) begin
            @(negedge clk);
            exp_en = (j % 4 == 0);
            checks++; if (clk_en !== exp_en) begin errors++; $display("FAIL fast_clk_en j=%0d: got %b want %b", j, clk_en, exp_en); end
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fast_busy j=%0d: got %b want 0", j, busy); end
        end
        checks++; if (stall_cnt !== 16'h0000) begin errors++; $display("FAIL fast_stall_cnt: got %h want 0000", stall_cnt); end
    endtask

`ifdef CPU_BUS_CTRL_WAIT_EN
    task automatic test_slow();
        bit          ok;
        logic        exp_en;
        logic        exp_busy;
        logic [15:0] exp_stall;
        wait_pulse(1'b0, ok);
        checks++; if (!ok) begin errors++; $display("FAIL slow_sync: got no clk_en within 40 cycles, want a pulse"); end
        addr = 16'h8000;
        for (int j = 1; j <= 24; j++) begin
            @(negedge clk);
            exp_en    = (j == 12) || (j == 24);
            exp_busy  = (j >= 4 && j <= 11) || (j >= 16 && j <= 23);
            exp_stall = (j < 4) ? 16'd0 : (j < 8) ? 16'd1 : (j < 16) ? 16'd2 : (j < 20) ? 16'd3 : 16'd4;
            checks++; if (clk_en !== exp_en) begin errors++; $display("FAIL slow_clk_en j=%0d: got %b want %b", j, clk_en, exp_en); end
            checks++; if (busy !== exp_busy) begin errors++; $display("FAIL slow_busy j=%0d: got %b want %b", j, busy, exp_busy); end
            checks++; if (stall_cnt !== exp_stall) begin errors++; $display("FAIL slow_stall_cnt j=%0d: got %0d want %0d", j, stall_cnt, exp_stall); end
        end
        addr = 16'h0200;
    endtask

    task automatic test_boundaries();
        bit          ok;
        logic        exp_en;
        logic        exp_busy;
        logic [15:0] exp_stall;
        wait_pulse(1'b0, ok);
        checks++; if (!ok) begin errors++; $display("FAIL bound_sync: got no clk_en within 40 cycles, want a pulse"); end
        addr = 16'h7FFF;
        for (int j = 1; j <= 8; j++) begin
            @(negedge clk);
            exp_en = (j % 4 == 0);
            checks++; if (clk_en !== exp_en) begin errors++; $display("FAIL bound_7fff_clk_en j=%0d: got %b want %b", j, clk_en, exp_en); end
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bound_7fff_busy j=%0d: got %b want 0", j, busy); end
        end
        checks++; if (stall_cnt !== 16'd4) begin errors++; $display("FAIL bound_7fff_stall_cnt: got %0d want 4", stall_cnt); end
        addr = 16'hFFFF;
        for (int j = 1; j <= 12; j++) begin
            @(negedge clk);
            exp_en    = (j == 12);
            exp_busy  = (j >= 4 && j <= 11);
            exp_stall = (j < 4) ? 16'd4 : (j < 8) ? 16'd5 : 16'd6;
            checks++; if (clk_en !== exp_en) begin errors++; $display("FAIL bound_ffff_clk_en j=%0d: got %b want %b", j, clk_en, exp_en); end
            checks++; if (busy !== exp_busy) begin errors++; $display("FAIL bound_ffff_busy j=%0d: got %b want %b", j, busy, exp_busy); end
            checks++; if (stall_cnt !== exp_stall) begin errors++; $display("FAIL bound_ffff_stall_cnt j=%0d: got %0d want %0d", j, stall_cnt, exp_stall); end
        end
        addr = 16'h0200;
    endtask
`else
    task automatic test_no_wait();
        bit   ok;
        logic exp_en;
        wait_pulse(1'b0, ok);
        checks++; if (!ok) begin errors++; $display("FAIL nowait_sync: got no clk_en within 40 cycles, want a pulse"); end
        addr = 16'h8000;
        for (int j = 1; j <= 12; j++) begin
            @(negedge clk);
            exp_en = (j % 4 == 0);
            checks++; if (clk_en !== exp_en) begin errors++; $display("FAIL nowait_clk_en j=%0d: got %b want %b", j, clk_en, exp_en); end
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL nowait_busy j=%0d: got %b want 0", j, busy); end
            checks++; if (stall_cnt !== 16'h0000) begin errors++; $display("FAIL nowait_stall_cnt j=%0d: got %h want 0000", j, stall_cnt); end
        end
        addr = 16'h0200;
    endtask
`endif

    task automatic test_wait_states_zero();
        bit   ok;
        logic exp_en;
        wait_pulse(1'b1, ok);
        checks++; if (!ok) begin errors++; $display("FAIL ws0_sync: got no clk_en within 40 cycles, want a pulse"); end
        for (int j = 1; j <= 12; j++) begin
            @(negedge clk);
            exp_en = (j % 4 == 0);
            checks++; if (clk_en0 !== exp_en) begin errors++; $display("FAIL ws0_clk_en j=%0d: got %b want %b", j, clk_en0, exp_en); end
            checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL ws0_busy j=%0d: got %b want 0", j, busy0); end
        end
        checks++; if (stall_cnt0 !== 16'h0000) begin errors++; $display("FAIL ws0_stall_cnt: got %h want 0000", stall_cnt0); end
    endtask

    task automatic test_reset_mid_wait();
        bit          ok;
        logic        exp_en;
        logic        exp_rn;
        logic        exp_busy;
        logic [15:0] exp_stall;
        wait_pulse(1'b0, ok);
        checks++; if (!ok) begin errors++; $display("FAIL midrst_sync: got no clk_en within 40 cycles, want a pulse"); end
        addr = 16'h8000;
        repeat (6) @(negedge clk);
`ifdef CPU_BUS_CTRL_WAIT_EN
        exp_busy = 1'b1;
`else
        exp_busy = 1'b0;
`endif
        checks++; if (busy !== exp_busy) begin errors++; $display("FAIL midrst_pre_busy: got %b want %b", busy, exp_busy); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", busy); end
        checks++; if (cpu_rstn !== 1'b0) begin errors++; $display("FAIL midrst_cpu_rstn: got %b want 0", cpu_rstn); end
        checks++; if (stall_cnt !== 16'h0000) begin errors++; $display("FAIL midrst_stall_cnt: got %h want 0000", stall_cnt); end
        checks++; if (clk_en !== 1'b0) begin errors++; $display("FAIL midrst_clk_en: got %b want 0", clk_en); end
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
`ifdef CPU_BUS_CTRL_WAIT_EN
            exp_en = (k == 4) || (k == 8) || (k == 12);
`else
            exp_en = (k % 4 == 0);
`endif
            exp_rn = (k >= 13);
            checks++; if (clk_en !== exp_en) begin errors++; $display("FAIL restretch_clk_en k=%0d: got %b want %b", k, clk_en, exp_en); end
            checks++; if (cpu_rstn !== exp_rn) begin errors++; $display("FAIL restretch_cpu_rstn k=%0d: got %b want %b", k, cpu_rstn, exp_rn); end
        end
`ifdef CPU_BUS_CTRL_WAIT_EN
        exp_busy  = 1'b1;
        exp_stall = 16'd1;
`else
        exp_busy  = 1'b0;
        exp_stall = 16'd0;
`endif
        checks++; if (busy !== exp_busy) begin errors++; $display("FAIL restretch_busy: got %b want %b", busy, exp_busy); end
        checks++; if (stall_cnt !== exp_stall) begin errors++; $display("FAIL restretch_stall_cnt: got %0d want %0d", stall_cnt, exp_stall); end
        addr = 16'h0200;
    endtask

    initial begin
        test_reset();
        test_fast();
`ifdef CPU_BUS_CTRL_WAIT_EN
        test_slow();
        test_boundaries();
`else
        test_no_wait();
`endif
        test_wait_states_zero();
        test_reset_mid_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
